// File: rtl/lagarto_pmu_pkg.sv
// Shared constants and FSM state type for the Lagarto PMU counter block.
package lagarto_pmu_pkg;

    localparam int unsigned NUM_EVENTS_DEF = 25;
    localparam int unsigned ADDR_W         = 6;

    localparam logic [ADDR_W-1:0] ADDR_ENABLE  = 6'd32;
    localparam logic [ADDR_W-1:0] ADDR_OVF     = 6'd33;
    localparam logic [ADDR_W-1:0] ADDR_OVF_IRQ = 6'd34;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 6'd35;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } pmu_state_e;

endpackage

// File: rtl/lagarto_pmu_counter.sv
// Single event counter: clear beats software load, load beats increment.
module lagarto_pmu_counter #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic [CNT_W-1:0] value,
    output logic             ovf_pulse
);

    // Wrap happens on the same edge the parent latches the overflow flag.
    assign ovf_pulse = inc & ~load & ~clear & (&value);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lagarto_pmu_counters.sv
// PMU event counter bank with a register access port, overflow tracking
// and a sequential clear-all engine.
module lagarto_pmu_counters
    import lagarto_pmu_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = NUM_EVENTS_DEF,
    parameter int unsigned CNT_W      = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_EVENTS-1:0] pmu_sig_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [5:0]            req_addr_i,
    input  logic [63:0]           req_wdata_i,
    output logic                  resp_valid_o,
    output logic [63:0]           resp_rdata_o,
    output logic                  ovf_irq_o
);

    localparam int unsigned IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_EVENTS - 1);

    pmu_state_e            state;
    pmu_state_e            state_next;
    logic [IDX_W-1:0]      idx;
    logic [NUM_EVENTS-1:0] sig_q;
    logic [NUM_EVENTS-1:0] enable;
    logic [NUM_EVENTS-1:0] ovf;
    logic [NUM_EVENTS-1:0] ovf_next;
    logic [NUM_EVENTS-1:0] ovf_irq_mask;
    logic [NUM_EVENTS-1:0] ovf_irq_mask_next;
    logic                  ctrl_en;

    logic [CNT_W-1:0]      cnt_val [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] inc;
    logic [NUM_EVENTS-1:0] load;
    logic [NUM_EVENTS-1:0] clear;
    logic [NUM_EVENTS-1:0] ovf_pulse;

    logic        accept;
    logic        wr;
    logic        wr_ctrl;
    logic        clear_start;
    logic        clear_done;
    logic [63:0] rd_mux;

    assign accept      = req_valid_i & req_ready_o;
    assign wr          = accept & req_we_i;
    assign wr_ctrl     = wr && (req_addr_i == ADDR_CTRL);
    assign clear_start = wr_ctrl & req_wdata_i[1];
    assign clear_done  = (state == ST_CLEAR) && (idx == IDX_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (clear_start) state_next = ST_CLEAR;
            ST_CLEAR: if (idx == IDX_LAST) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cnt
        assign inc[g]   = sig_q[g] & enable[g] & ctrl_en & (state == ST_IDLE);
        assign load[g]  = wr && (req_addr_i == 6'(g));
        assign clear[g] = (state == ST_CLEAR) && (idx == IDX_W'(g));

        lagarto_pmu_counter #(
            .CNT_W(CNT_W)
        ) u_counter (
            .clk      (clk_i),
            .rst      (rst_i),
            .inc      (inc[g]),
            .load     (load[g]),
            .load_val (req_wdata_i[CNT_W-1:0]),
            .clear    (clear[g]),
            .value    (cnt_val[g]),
            .ovf_pulse(ovf_pulse[g])
        );
    end

    // A fresh overflow survives a simultaneous write-1-to-clear.
    always_comb begin
        ovf_next = ovf;
        if (wr && (req_addr_i == ADDR_OVF)) begin
            ovf_next = ovf_next & ~req_wdata_i[NUM_EVENTS-1:0];
        end
        ovf_next = ovf_next | ovf_pulse;
        if (clear_done) begin
            ovf_next = '0;
        end
    end

    always_comb begin
        ovf_irq_mask_next = ovf_irq_mask;
        if (wr && (req_addr_i == ADDR_OVF_IRQ)) begin
            ovf_irq_mask_next = req_wdata_i[NUM_EVENTS-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (req_addr_i == 6'(i)) rd_mux = 64'(cnt_val[i]);
        end
        case (req_addr_i)
            ADDR_ENABLE:  rd_mux = 64'(enable);
            ADDR_OVF:     rd_mux = 64'(ovf);
            ADDR_OVF_IRQ: rd_mux = 64'(ovf_irq_mask);
            ADDR_CTRL:    rd_mux = 64'(ctrl_en);
            default:      ;
        endcase
    end

    // Global enable is written immediately; counting is already suspended during a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q        <= '0;
            enable       <= '1;
            ovf          <= '0;
            ovf_irq_mask <= '0;
            ctrl_en      <= 1'b1;
            idx          <= '0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            ovf_irq_o    <= 1'b0;
        end else begin
            sig_q        <= pmu_sig_i;
            ovf          <= ovf_next;
            ovf_irq_mask <= ovf_irq_mask_next;
            if (wr && (req_addr_i == ADDR_ENABLE)) begin
                enable <= req_wdata_i[NUM_EVENTS-1:0];
            end
            if (wr_ctrl) begin
                ctrl_en <= req_wdata_i[0];
            end
            if ((state == ST_CLEAR) && !clear_done) begin
                idx <= idx + IDX_W'(1);
            end else begin
                idx <= '0;
            end
            req_ready_o  <= !accept && (state_next == ST_IDLE);
            resp_valid_o <= accept;
            resp_rdata_o <= (accept && !req_we_i) ? rd_mux : 64'd0;
            ovf_irq_o    <= |(ovf_next & ovf_irq_mask_next);
        end
    end

endmodule

// File: tb/tb_lagarto_pmu_counters.sv
// Self-checking bench for lagarto_pmu_counters (25 events, 8-bit counters).
module tb_lagarto_pmu_counters;

    localparam int NE = 25;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [NE-1:0] pmu_sig;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [5:0]    req_addr;
    logic [63:0]   req_wdata;
    logic          resp_valid;
    logic [63:0]   resp_rdata;
    logic          ovf_irq;

    int checks   = 0;
    int failures = 0;

    lagarto_pmu_counters #(
        .NUM_EVENTS(NE),
        .CNT_W     (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pmu_sig_i   (pmu_sig),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .resp_valid_o(resp_valid),
        .resp_rdata_o(resp_rdata),
        .ovf_irq_o   (ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: registers as plain arrays; a clear zeroes counters at once
    // and just keeps the port busy for NE cycles, dropping OVF when it ends.
    int unsigned   m_cnt [NE];
    logic [NE-1:0] m_en, m_ovf, m_irqm, m_sigq, m_new;
    logic          m_ctrl, m_acc;
    int            m_clear_left;
    logic [63:0]   m_rd;
    logic          exp_ready, exp_rv, exp_irq;
    logic [63:0]   exp_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) m_cnt[i] = 0;
            m_en = '1; m_ovf = '0; m_irqm = '0; m_sigq = '0; m_ctrl = 1'b1;
            m_clear_left = 0;
            exp_ready = 1'b1; exp_rv = 1'b0; exp_rdata = '0; exp_irq = 1'b0;
        end else begin
            m_acc = req_valid && exp_ready;
            m_rd  = '0;
            if (m_acc && !req_we) begin
                if (int'(req_addr) < NE) m_rd = 64'(m_cnt[int'(req_addr)]);
                else if (req_addr == 6'd32) m_rd = 64'(m_en);
                else if (req_addr == 6'd33) m_rd = 64'(m_ovf);
                else if (req_addr == 6'd34) m_rd = 64'(m_irqm);
                else if (req_addr == 6'd35) m_rd = 64'(m_ctrl);
            end
            m_new = '0;
            for (int i = 0; i < NE; i++) begin
                if (m_acc && req_we && int'(req_addr) == i) begin
                    m_cnt[i] = int'(req_wdata[CW-1:0]);
                end else if (m_ctrl && m_clear_left == 0 && m_en[i] && m_sigq[i]) begin
                    m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
                    if (m_cnt[i] == 0) m_new[i] = 1'b1;
                end
            end
            if (m_acc && req_we && req_addr == 6'd32) m_en = req_wdata[NE-1:0];
            if (m_acc && req_we && req_addr == 6'd33) m_ovf = m_ovf & ~req_wdata[NE-1:0];
            if (m_acc && req_we && req_addr == 6'd34) m_irqm = req_wdata[NE-1:0];
            m_ovf = m_ovf | m_new;
            if (m_clear_left > 0) begin
                m_clear_left = m_clear_left - 1;
                if (m_clear_left == 0) m_ovf = '0;
            end
            if (m_acc && req_we && req_addr == 6'd35) begin
                m_ctrl = req_wdata[0];
                if (req_wdata[1]) begin
                    for (int i = 0; i < NE; i++) m_cnt[i] = 0;
                    m_clear_left = NE;
                end
            end
            exp_ready = !m_acc && m_clear_left == 0;
            exp_rv    = m_acc;
            exp_rdata = m_rd;
            exp_irq   = |(m_ovf & m_irqm);
            m_sigq    = pmu_sig;
        end
    end

    // Bus access: waits (bounded) for ready, returns read data from the response cycle.
    task automatic access(input logic we, input logic [5:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata);
        int waitc = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        while (req_ready !== 1'b1 && waitc < 64) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL access_ready addr=%0d: ready=%b never rose within 64 cycles", addr, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        rdata = resp_rdata;
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL access_resp addr=%0d: resp_valid=%b expected 1", addr, resp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [63:0] rd;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, ovf_irq} !== 3'b100 || resp_rdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs: ready/rv/irq=%b rdata=%h expected 100 and 0",
                     {req_ready, resp_valid, ovf_irq}, resp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        access(1'b0, 6'd32, '0, rd);
        checks++;
        if (rd !== 64'h1FF_FFFF) begin failures++; $display("FAIL reset_enable: got %h expected 1ffffff", rd); end
        access(1'b0, 6'd33, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL reset_ovf: got %h expected 0", rd); end
        access(1'b0, 6'd34, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL reset_irqmask: got %h expected 0", rd); end
        access(1'b0, 6'd35, '0, rd);
        checks++;
        if (rd !== 64'd1) begin failures++; $display("FAIL reset_ctrl: got %h expected 1", rd); end
        access(1'b0, 6'd24, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL reset_cnt24: got %h expected 0", rd); end
    endtask

    task automatic test_cycle_count();
        logic [63:0] rd;
        pmu_sig = '0; pmu_sig[0] = 1'b1;
        repeat (100) @(negedge clk);
        pmu_sig = '0;
        access(1'b0, 6'd0, '0, rd);
        checks++;
        if (rd !== 64'd99) begin failures++; $display("FAIL cyc_cnt_early: got %0d expected 99", rd); end
        access(1'b0, 6'd0, '0, rd);
        checks++;
        if (rd !== 64'd100) begin failures++; $display("FAIL cyc_cnt_final: got %0d expected 100", rd); end
    endtask

    task automatic test_overflow();
        logic [63:0] rd;
        access(1'b1, 6'd5, 64'hFF, rd);
        access(1'b1, 6'd34, 64'h20, rd);
        pmu_sig = '0; pmu_sig[5] = 1'b1;
        @(negedge clk);
        pmu_sig = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ovf_irq !== 1'b1) begin failures++; $display("FAIL ovf_irq_set: got %b expected 1", ovf_irq); end
        access(1'b0, 6'd5, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL ovf_wrap: got %h expected 0", rd); end
        access(1'b0, 6'd33, '0, rd);
        checks++;
        if (rd !== 64'h20) begin failures++; $display("FAIL ovf_status: got %h expected 20", rd); end
        access(1'b1, 6'd33, 64'h20, rd);
        checks++;
        if (ovf_irq !== 1'b0) begin failures++; $display("FAIL ovf_irq_w1c: got %b expected 0", ovf_irq); end
        access(1'b0, 6'd33, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL ovf_w1c_status: got %h expected 0", rd); end
    endtask

    task automatic test_write_wins();
        logic [63:0] rd;
        pmu_sig = '0; pmu_sig[3] = 1'b1;
        @(negedge clk);
        pmu_sig = '0;
        access(1'b1, 6'd3, 64'h10, rd);
        access(1'b0, 6'd3, '0, rd);
        checks++;
        if (rd !== 64'h10) begin failures++; $display("FAIL write_wins: got %h expected 10", rd); end
    endtask

    task automatic test_clear();
        logic [63:0] rd;
        int low = 0;
        access(1'b1, 6'd7, 64'hFF, rd);
        pmu_sig = '1;
        repeat (3) @(negedge clk);
        pmu_sig = '0;
        repeat (2) @(negedge clk);
        access(1'b0, 6'd33, '0, rd);
        checks++;
        if (rd !== 64'h80) begin failures++; $display("FAIL clear_pre_ovf: got %h expected 80", rd); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd35; req_wdata = 64'h3;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        while (req_ready !== 1'b1 && low < 100) begin
            low++;
            pmu_sig = (low < NE) ? '1 : '0;
            @(negedge clk);
        end
        pmu_sig = '0;
        checks++;
        if (low != NE) begin failures++; $display("FAIL clear_busy_len: got %0d expected %0d", low, NE); end
        for (int i = 0; i < NE; i++) begin
            access(1'b0, 6'(i), '0, rd);
            checks++;
            if (rd !== 64'd0) begin failures++; $display("FAIL clear_cnt%0d: got %h expected 0", i, rd); end
        end
        access(1'b0, 6'd33, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL clear_ovf: got %h expected 0", rd); end
        // Global enable written alongside a clear takes effect after it.
        access(1'b1, 6'd35, 64'h2, rd);
        access(1'b0, 6'd35, '0, rd);
        pmu_sig = 25'h1;
        repeat (5) @(negedge clk);
        pmu_sig = '0;
        repeat (2) @(negedge clk);
        access(1'b0, 6'd0, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL ctrl_disabled: got %h expected 0", rd); end
        access(1'b1, 6'd35, 64'h1, rd);
        pmu_sig = 25'h1;
        @(negedge clk);
        pmu_sig = '0;
        repeat (2) @(negedge clk);
        access(1'b0, 6'd0, '0, rd);
        checks++;
        if (rd !== 64'd1) begin failures++; $display("FAIL ctrl_reenabled: got %h expected 1", rd); end
    endtask

    task automatic test_enable_mask();
        logic [63:0] rd;
        access(1'b1, 6'd32, 64'h2, rd);
        pmu_sig = 25'h6;
        repeat (10) @(negedge clk);
        pmu_sig = '0;
        repeat (2) @(negedge clk);
        access(1'b0, 6'd1, '0, rd);
        checks++;
        if (rd !== 64'd10) begin failures++; $display("FAIL enable_cnt1: got %0d expected 10", rd); end
        access(1'b0, 6'd2, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL enable_cnt2: got %0d expected 0", rd); end
        access(1'b1, 6'd40, 64'hDEAD, rd);
        access(1'b0, 6'd40, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL unmapped_read: got %h expected 0", rd); end
        access(1'b1, 6'd32, 64'h1FF_FFFF, rd);
    endtask

    task automatic test_reset_mid_clear();
        logic [63:0] rd;
        access(1'b1, 6'd20, 64'h33, rd);
        access(1'b1, 6'd34, 64'hFF, rd);
        access(1'b1, 6'd32, 64'h5, rd);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd35; req_wdata = 64'h2;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL midclr_busy: ready=%b expected 0", req_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, ovf_irq} !== 3'b100 || resp_rdata !== 64'd0) begin
            failures++;
            $display("FAIL midclr_idle: ready/rv/irq=%b rdata=%h expected 100 and 0",
                     {req_ready, resp_valid, ovf_irq}, resp_rdata);
        end
        access(1'b0, 6'd32, '0, rd);
        checks++;
        if (rd !== 64'h1FF_FFFF) begin failures++; $display("FAIL midclr_enable: got %h expected 1ffffff", rd); end
        access(1'b0, 6'd34, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL midclr_irqmask: got %h expected 0", rd); end
        access(1'b0, 6'd35, '0, rd);
        checks++;
        if (rd !== 64'd1) begin failures++; $display("FAIL midclr_ctrl: got %h expected 1", rd); end
        access(1'b0, 6'd20, '0, rd);
        checks++;
        if (rd !== 64'd0) begin failures++; $display("FAIL midclr_cnt20: got %h expected 0", rd); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", c, req_ready, exp_ready); end
            checks++;
            if (resp_valid !== exp_rv) begin failures++; $display("FAIL rnd_resp_valid cyc=%0d: got %b expected %b", c, resp_valid, exp_rv); end
            checks++;
            if (resp_rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d addr=%0d: got %h expected %h", c, req_addr, resp_rdata, exp_rdata); end
            checks++;
            if (ovf_irq !== exp_irq) begin failures++; $display("FAIL rnd_irq cyc=%0d: got %b expected %b", c, ovf_irq, exp_irq); end
            pmu_sig    = NE'($urandom) | NE'(1);
            req_valid  = ($urandom_range(0, 9) < 4);
            req_we     = $urandom_range(0, 1) == 1;
            req_wdata  = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: req_addr = 6'($urandom_range(0, NE - 1));
                6, 7:             req_addr = 6'($urandom_range(32, 35));
                default:          req_addr = 6'($urandom_range(0, 63));
            endcase
            if (req_addr < 6'(NE) && $urandom_range(0, 1) == 1) req_wdata[7:0] = 8'hFE | 8'($urandom_range(0, 1));
            if (req_addr == 6'd35) begin
                req_wdata[0] = $urandom_range(0, 3) != 0;
                req_wdata[1] = $urandom_range(0, 7) == 0;
            end
        end
        req_valid = 1'b0;
        pmu_sig   = '0;
    endtask

    initial begin
        rst = 1'b1; pmu_sig = '0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_cycle_count();
        test_overflow();
        test_write_wins();
        test_clear();
        test_enable_mask();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
